spi_read_sequencer: RTL and testbench
=====================================

// Module: spi_read_sequencer
// PURPOSE
//  Upstream command stage for spi_flash_read. Walks a programmable table of flash regions
//  and issues one read segment per region to the reader (start_addr/end_addr/mode/read_req/
//  start_flag/switch_die_need), waiting on read_finish between segments.
//  Splits any region that crosses a die boundary into two segments; the second carries
//  switch_die_need. Reports overall busy/completed/error status to the top level.
// PARAMETERS
//  NUM_REGIONS  4             table depth (2..16); index width IDX_W = $clog2(NUM_REGIONS)
//  DIE_SIZE     32'h0400_0000 bytes per die; power of two
//  GAP_CYCLES   10            idle cycles between segments (reader settle time), >=1
//  ACK_TIMEOUT  255           max cycles waiting for read_finish to fall after issue
// PORTS
//  system_clk       in   1      system clock (PLL c0)
//  system_reset_n   in   1      asynchronous, active-low reset (PLL locked)
//  cfg_we           in   1      table write strobe; ignored while busy
//  cfg_idx          in   IDX_W  table entry index
//  cfg_start/cfg_end in  32     inclusive byte range of entry
//  cfg_mode         in   3      read mode for entry
//  cfg_valid        in   1      entry enable
//  go               in   1      start pulse; ignored unless state IDLE/DONE/ERROR
//  abort            in   1      level; terminates sequence
//  read_finish      in   1      from reader; 1 = idle/finished, 0 = reading
//  start_addr/end_addr out 32   segment range to reader, stable from ISSUE until segment done
//  mode             out  3      segment mode
//  switch_die_need  out  1      segment lies in a different die than the previous segment
//  read_req         out  1      one-cycle request pulse
//  start_flag       out  1      held high from ISSUE until read_finish rises
//  busy             out  1      sequence in progress
//  completed        out  1      level; all enabled entries read, until next go
//  error            out  1      level; bad entry or ack timeout, until next go
//  cur_idx          out  IDX_W  entry currently being served
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, table entries invalid, prev_die = 0.
//  FSM: IDLE -go-> LOAD; LOAD: scan cur_idx upward to the next valid entry;
//   none left -> DONE. CHECK: cfg_end < cfg_start -> ERROR. Otherwise form a segment:
//   seg_start = cur pointer; die = seg_start / DIE_SIZE;
//   seg_end = min(entry end, (die+1)*DIE_SIZE - 1); switch_die_need = (die != prev_die).
//   -> ISSUE.
//  ISSUE (1 cycle): read_req = 1, start_flag = 1 -> WAIT_ACK.
//  WAIT_ACK: read_finish == 0 -> WAIT_DONE; counter reaches ACK_TIMEOUT -> ERROR.
//  WAIT_DONE: read_finish rising edge (registered previous value 0, now 1) ->
//   start_flag = 0, prev_die = die -> GAP.
//  GAP: GAP_CYCLES cycles -> if seg_end < entry end: cur pointer = seg_end + 1 and go to
//   CHECK (split continuation); else cur_idx + 1 and go to LOAD.
//  DONE: completed = 1, busy = 0. ERROR: error = 1, busy = 0, start_flag = 0.
//  busy = 1 in every state except IDLE/DONE/ERROR. go from DONE/ERROR clears both flags
//   and restarts at index 0 with prev_die = 0.
//  Address arithmetic is 32-bit unsigned. seg_end + 1 never wraps, because a split only
//   occurs below the entry end. Entry end = 32'hFFFF_FFFF is legal.
//  Entry spans more than two dies: it splits repeatedly, one segment per die.
//  abort, any active state: start_flag/read_req drop next cycle, state -> IDLE,
//   completed = error = 0. The reader is left to finish or time out on its own.
//  go and abort in the same cycle: abort wins.
//  cfg_we while busy is dropped; table contents are unchanged.
//  Reset mid-sequence: immediate return to reset values.
// STRUCTURE
//  Shared package spi_pkg: state encoding localparams, MODE_* read-mode codes,
//   DIE_SIZE default.
//  Sub-module spi_region_table: NUM_REGIONS x {start, end, mode, valid} register file,
//   write port plus combinational read at cur_idx. Sequencer FSM and counters stay in
//   this module.
// TESTING
//  T1: entry0 = {0x0, 0xFF, mode 1}, go; reader model drops read_finish 2 cycles after
//   read_req -> one read_req, start_addr=0, end_addr=0xFF, switch_die_need=0; completed=1.
//  T2: entry0 = {0x03FF_FF00, 0x0400_00FF} -> segments [0x03FF_FF00..0x03FF_FFFF] sw=0,
//   then [0x0400_0000..0x0400_00FF] sw=1; GAP_CYCLES idle cycles between them.
//  T3: entries 0, 2 valid, entry 1 invalid -> two segments only, cur_idx goes 0 then 2;
//   no valid entries at all -> completed within 3 cycles of go.
//  T4: reader never drops read_finish -> error=1 after ACK_TIMEOUT cycles, start_flag=0,
//   busy=0.
//  T5: entry {0x200, 0x100} -> error with no read_req; abort during WAIT_DONE -> IDLE,
//   busy=0, next go restarts at idx 0.
//  T6: cfg_we during busy ignored; reset asserted in WAIT_DONE -> all outputs 0 that cycle.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash read sequencer and its region table.
package spi_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  localparam logic [2:0] MODE_READ      = 3'd0;
  localparam logic [2:0] MODE_FAST_READ = 3'd1;
  localparam logic [2:0] MODE_DUAL      = 3'd2;
  localparam logic [2:0] MODE_QUAD      = 3'd3;
  localparam logic [2:0] MODE_QUAD_IO   = 3'd4;

  localparam logic [ADDR_W-1:0] DIE_SIZE_DEFAULT = 32'h0400_0000;

endpackage

// File: rtl/spi_region_table.sv
// Register file of flash regions {start, end, mode, valid} with one write port
// and a combinational read port; valid bits are also exported as a vector.
module spi_region_table
  import spi_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [ADDR_W-1:0]      wr_start,
  input  logic [ADDR_W-1:0]      wr_end,
  input  logic [2:0]             wr_mode,
  input  logic                   wr_valid,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [ADDR_W-1:0]      rd_start,
  output logic [ADDR_W-1:0]      rd_end,
  output logic [2:0]             rd_mode,
  output logic [NUM_REGIONS-1:0] valid_vec
);

  logic [ADDR_W-1:0] start_mem [NUM_REGIONS];
  logic [ADDR_W-1:0] end_mem   [NUM_REGIONS];
  logic [2:0]        mode_mem  [NUM_REGIONS];

  for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        start_mem[gi] <= '0;
        end_mem[gi]   <= '0;
        mode_mem[gi]  <= '0;
        valid_vec[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        start_mem[gi] <= wr_start;
        end_mem[gi]   <= wr_end;
        mode_mem[gi]  <= wr_mode;
        valid_vec[gi] <= wr_valid;
      end
    end
  end

  assign rd_start = start_mem[rd_idx];
  assign rd_end   = end_mem[rd_idx];
  assign rd_mode  = mode_mem[rd_idx];

endmodule

// File: rtl/spi_read_sequencer.sv
// Walks the region table and issues one read segment per region (split at die
// boundaries) to the SPI flash reader, with handshake timeout and abort.
module spi_read_sequencer
  import spi_pkg::*;
#(
  parameter int               NUM_REGIONS = 4,
  parameter logic [ADDR_W-1:0] DIE_SIZE   = DIE_SIZE_DEFAULT,
  parameter int               GAP_CYCLES  = 10,
  parameter int               ACK_TIMEOUT = 255,
  localparam int              IDX_W       = $clog2(NUM_REGIONS)
) (
  input  logic              system_clk,
  input  logic              system_reset_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [31:0]       cfg_start,
  input  logic [31:0]       cfg_end,
  input  logic [2:0]        cfg_mode,
  input  logic              cfg_valid,
  input  logic              go,
  input  logic              abort,
  input  logic              read_finish,
  output logic [31:0]       start_addr,
  output logic [31:0]       end_addr,
  output logic [2:0]        mode,
  output logic              switch_die_need,
  output logic              read_req,
  output logic              start_flag,
  output logic              busy,
  output logic              completed,
  output logic              error,
  output logic [IDX_W-1:0]  cur_idx
);

  localparam int               DIE_SHIFT = $clog2(DIE_SIZE);
  localparam logic [ADDR_W-1:0] DIE_MASK = DIE_SIZE - 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGIONS - 1);

  seq_state_t              state;
  logic [ADDR_W-1:0]       cur_ptr;
  logic [ADDR_W-1:0]       prev_die;
  logic [ADDR_W-1:0]       seg_die;
  logic [15:0]             cnt;
  logic                    finish_prev;

  logic [ADDR_W-1:0]       ent_start;
  logic [ADDR_W-1:0]       ent_end;
  logic [2:0]              ent_mode;
  logic [NUM_REGIONS-1:0]  valid_vec;
  logic [IDX_W-1:0]        rd_idx;
  logic                    scan_found;
  logic [IDX_W-1:0]        scan_idx;
  logic [ADDR_W-1:0]       ptr_die;
  logic [ADDR_W-1:0]       die_last;
  logic [ADDR_W-1:0]       seg_end;

  // LOAD reads the entry it is about to select so the start pointer is ready for CHECK.
  assign rd_idx = (state == ST_LOAD) ? scan_idx : cur_idx;

  spi_region_table #(
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W)
  ) u_table (
    .clk       (system_clk),
    .rst_n     (system_reset_n),
    .wr_en     (cfg_we && !busy),
    .wr_idx    (cfg_idx),
    .wr_start  (cfg_start),
    .wr_end    (cfg_end),
    .wr_mode   (cfg_mode),
    .wr_valid  (cfg_valid),
    .rd_idx    (rd_idx),
    .rd_start  (ent_start),
    .rd_end    (ent_end),
    .rd_mode   (ent_mode),
    .valid_vec (valid_vec)
  );

  always_comb begin
    scan_found = 1'b0;
    scan_idx   = cur_idx;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (valid_vec[i] && (i >= int'(cur_idx))) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(i);
      end
    end
  end

  assign ptr_die  = cur_ptr >> DIE_SHIFT;
  assign die_last = cur_ptr | DIE_MASK;
  assign seg_end  = (ent_end < die_last) ? ent_end : die_last;

  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state           <= ST_IDLE;
      cur_ptr         <= '0;
      prev_die        <= '0;
      seg_die         <= '0;
      cnt             <= '0;
      finish_prev     <= 1'b0;
      start_addr      <= '0;
      end_addr        <= '0;
      mode            <= '0;
      switch_die_need <= 1'b0;
      read_req        <= 1'b0;
      start_flag      <= 1'b0;
      busy            <= 1'b0;
      completed       <= 1'b0;
      error           <= 1'b0;
      cur_idx         <= '0;
    end else begin
      finish_prev <= read_finish;
      read_req    <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        start_flag <= 1'b0;
        busy       <= 1'b0;
        completed  <= 1'b0;
        error      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (go) begin
              state     <= ST_LOAD;
              busy      <= 1'b1;
              completed <= 1'b0;
              error     <= 1'b0;
              cur_idx   <= '0;
              prev_die  <= '0;
            end
          end
          ST_LOAD: begin
            if (scan_found) begin
              cur_idx <= scan_idx;
              cur_ptr <= ent_start;
              state   <= ST_CHECK;
            end else begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              completed <= 1'b1;
            end
          end
          ST_CHECK: begin
            if (ent_end < ent_start) begin
              state      <= ST_ERROR;
              busy       <= 1'b0;
              error      <= 1'b1;
              start_flag <= 1'b0;
            end else begin
              start_addr      <= cur_ptr;
              end_addr        <= seg_end;
              mode            <= ent_mode;
              switch_die_need <= (ptr_die != prev_die);
              seg_die         <= ptr_die;
              read_req        <= 1'b1;
              start_flag      <= 1'b1;
              state           <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            cnt   <= '0;
            state <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (!read_finish) begin
              state <= ST_WAIT_DONE;
            end else if (cnt == 16'(ACK_TIMEOUT)) begin
              state      <= ST_ERROR;
              busy       <= 1'b0;
              error      <= 1'b1;
              start_flag <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          ST_WAIT_DONE: begin
            if (read_finish && !finish_prev) begin
              start_flag <= 1'b0;
              prev_die   <= seg_die;
              cnt        <= '0;
              state      <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (cnt == 16'(GAP_CYCLES - 1)) begin
              // A segment cut short by a die boundary continues from the next byte.
              if (end_addr < ent_end) begin
                cur_ptr <= end_addr + 32'd1;
                state   <= ST_CHECK;
              end else if (cur_idx == LAST_IDX) begin
                state     <= ST_DONE;
                busy      <= 1'b0;
                completed <= 1'b1;
              end else begin
                cur_idx <= cur_idx + 1'b1;
                state   <= ST_LOAD;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_read_sequencer.sv
// Directed bench for spi_read_sequencer with a behavioural reader that answers
// each read_req by dropping read_finish for a programmable time.
`timescale 1ns/1ps
module tb_spi_read_sequencer;
  import spi_pkg::*;

  localparam int NR  = 4;
  localparam int GAP = 10;
  localparam int ACK = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [31:0] cfg_start = '0;
  logic [31:0] cfg_end = '0;
  logic [2:0]  cfg_mode = '0;
  logic        cfg_valid = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        read_finish = 1'b1;
  logic [31:0] start_addr;
  logic [31:0] end_addr;
  logic [2:0]  mode;
  logic        switch_die_need;
  logic        read_req;
  logic        start_flag;
  logic        busy;
  logic        completed;
  logic        error;
  logic [1:0]  cur_idx;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int reader_on = 1;
  int busy_len = 4;
  int phase = 0;
  int dly = 0;
  int last_rise = 0;

  typedef struct {
    logic [31:0] s;
    logic [31:0] e;
    logic [2:0]  m;
    logic        sw;
    logic [1:0]  idx;
    int          gap;
    int          at;
  } seg_t;
  seg_t segs[$];

  always #5 clk = ~clk;

  spi_read_sequencer #(
    .NUM_REGIONS (NR),
    .DIE_SIZE    (32'h0400_0000),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .system_clk      (clk),
    .system_reset_n  (rst_n),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_start       (cfg_start),
    .cfg_end         (cfg_end),
    .cfg_mode        (cfg_mode),
    .cfg_valid       (cfg_valid),
    .go              (go),
    .abort           (abort),
    .read_finish     (read_finish),
    .start_addr      (start_addr),
    .end_addr        (end_addr),
    .mode            (mode),
    .switch_die_need (switch_die_need),
    .read_req        (read_req),
    .start_flag      (start_flag),
    .busy            (busy),
    .completed       (completed),
    .error           (error),
    .cur_idx         (cur_idx)
  );

  always @(posedge clk) cyc++;

  // Reader: drops read_finish 2 cycles after read_req, holds it low busy_len cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
      read_finish = 1'b1;
    end else begin
      case (phase)
        0: if (read_req && reader_on != 0) begin phase = 1; dly = 2; end
        1: begin
          dly--;
          if (dly == 0) begin read_finish = 1'b0; phase = 2; dly = busy_len; end
        end
        default: begin
          dly--;
          if (dly == 0) begin read_finish = 1'b1; phase = 0; last_rise = cyc; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && read_req) begin
      seg_t x;
      x.s = start_addr; x.e = end_addr; x.m = mode; x.sw = switch_die_need;
      x.idx = cur_idx; x.gap = cyc - last_rise; x.at = cyc;
      segs.push_back(x);
      $display("seg %0d: idx=%0d [%h..%h] mode=%0d sw=%0b", segs.size() - 1, cur_idx, start_addr, end_addr, mode, switch_die_need);
    end
  end

  task automatic write_entry(input int idx, input logic [31:0] s, input logic [31:0] e,
                             input logic [2:0] m, input logic v);
    @(negedge clk);
    cfg_idx = 2'(idx); cfg_start = s; cfg_end = e; cfg_mode = m; cfg_valid = v; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NR; i++) write_entry(i, 32'h0, 32'h0, 3'd0, 1'b0);
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_idle: busy=%0b after %0d cycles, want 0", name, busy, budget);
    else passed++;
  endtask

  task automatic wait_in_read(input string name);
    int n = 0;
    while (!(start_flag === 1'b1 && read_finish === 1'b0) && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!(start_flag === 1'b1 && read_finish === 1'b0))
      $display("FAIL %s_reach_read: start_flag=%0b read_finish=%0b, want 1/0", name, start_flag, read_finish);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passed++;
    checks++; if (read_req !== 1'b0) $display("FAIL reset_read_req: got %0b want 0", read_req); else passed++;
    checks++; if (start_flag !== 1'b0) $display("FAIL reset_start_flag: got %0b want 0", start_flag); else passed++;
    checks++; if ({completed, error} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {completed, error}); else passed++;
    checks++; if (start_addr !== 32'h0 || end_addr !== 32'h0) $display("FAIL reset_addr: got %h/%h want 0/0", start_addr, end_addr); else passed++;
    checks++; if (cur_idx !== 2'd0) $display("FAIL reset_cur_idx: got %0d want 0", cur_idx); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %0b want 0", busy); else passed++;
  endtask

  task automatic test_single();
    write_entry(0, 32'h0, 32'hFF, 3'd1, 1'b1);
    segs.delete();
    pulse_go();
    wait_idle(500, "single");
    checks++; if (segs.size() != 1) $display("FAIL single_count: got %0d want 1", segs.size()); else passed++;
    if (segs.size() >= 1) begin
      checks++; if (segs[0].s !== 32'h0 || segs[0].e !== 32'hFF) $display("FAIL single_range: got %h..%h want 0..ff", segs[0].s, segs[0].e); else passed++;
      checks++; if (segs[0].sw !== 1'b0) $display("FAIL single_sw: got %0b want 0", segs[0].sw); else passed++;
      checks++; if (segs[0].m !== 3'd1) $display("FAIL single_mode: got %0d want 1", segs[0].m); else passed++;
    end
    checks++; if (completed !== 1'b1 || error !== 1'b0) $display("FAIL single_status: completed=%0b error=%0b want 1/0", completed, error); else passed++;
  endtask

  task automatic test_die_split();
    write_entry(0, 32'h03FF_FF00, 32'h0400_00FF, 3'd2, 1'b1);
    segs.delete();
    pulse_go();
    wait_idle(500, "split");
    checks++; if (segs.size() != 2) $display("FAIL split_count: got %0d want 2", segs.size()); else passed++;
    if (segs.size() >= 2) begin
      checks++; if (segs[0].s !== 32'h03FF_FF00 || segs[0].e !== 32'h03FF_FFFF || segs[0].sw !== 1'b0)
        $display("FAIL split_seg0: got %h..%h sw=%0b want 03ffff00..03ffffff sw=0", segs[0].s, segs[0].e, segs[0].sw); else passed++;
      checks++; if (segs[1].s !== 32'h0400_0000 || segs[1].e !== 32'h0400_00FF || segs[1].sw !== 1'b1)
        $display("FAIL split_seg1: got %h..%h sw=%0b want 04000000..040000ff sw=1", segs[1].s, segs[1].e, segs[1].sw); else passed++;
      // rise seen at next edge, GAP cycles in GAP, one cycle in CHECK, then read_req.
      checks++; if (segs[1].gap != GAP + 2) $display("FAIL split_gap: got %0d want %0d", segs[1].gap, GAP + 2); else passed++;
    end
  endtask

  task automatic test_multi_die();
    logic [31:0] exp_s [4] = '{32'h03FF_FFF0, 32'h0400_0000, 32'h0800_0000, 32'hFFFF_FF00};
    logic [31:0] exp_e [4] = '{32'h03FF_FFFF, 32'h07FF_FFFF, 32'h0800_000F, 32'hFFFF_FFFF};
    logic        exp_sw[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]  exp_i [4] = '{2'd0, 2'd0, 2'd0, 2'd1};
    clear_table();
    write_entry(0, 32'h03FF_FFF0, 32'h0800_000F, 3'd2, 1'b1);
    write_entry(1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 3'd3, 1'b1);
    segs.delete();
    pulse_go();
    wait_idle(800, "multi");
    checks++; if (segs.size() != 4) $display("FAIL multi_count: got %0d want 4", segs.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (i < segs.size()) begin
        checks++;
        if (segs[i].s !== exp_s[i] || segs[i].e !== exp_e[i] || segs[i].sw !== exp_sw[i] || segs[i].idx !== exp_i[i])
          $display("FAIL multi_seg%0d: got idx%0d %h..%h sw=%0b want idx%0d %h..%h sw=%0b", i,
                   segs[i].idx, segs[i].s, segs[i].e, segs[i].sw, exp_i[i], exp_s[i], exp_e[i], exp_sw[i]);
        else passed++;
      end
    end
    checks++; if (completed !== 1'b1) $display("FAIL multi_completed: got %0b want 1", completed); else passed++;
  endtask

  task automatic test_skip();
    int n;
    clear_table();
    write_entry(0, 32'h1000, 32'h10FF, 3'd3, 1'b1);
    write_entry(1, 32'h1800, 32'h18FF, 3'd5, 1'b0);
    write_entry(2, 32'h2000, 32'h20FF, 3'd4, 1'b1);
    segs.delete();
    pulse_go();
    wait_idle(500, "skip");
    checks++; if (segs.size() != 2) $display("FAIL skip_count: got %0d want 2", segs.size()); else passed++;
    if (segs.size() >= 2) begin
      checks++; if (segs[0].idx !== 2'd0 || segs[0].s !== 32'h1000 || segs[0].m !== 3'd3)
        $display("FAIL skip_first: got idx%0d %h mode%0d want idx0 1000 mode3", segs[0].idx, segs[0].s, segs[0].m); else passed++;
      checks++; if (segs[1].idx !== 2'd2 || segs[1].s !== 32'h2000 || segs[1].e !== 32'h20FF)
        $display("FAIL skip_second: got idx%0d %h..%h want idx2 2000..20ff", segs[1].idx, segs[1].s, segs[1].e); else passed++;
    end
    clear_table();
    segs.delete();
    pulse_go();
    n = 0;
    while (completed !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    checks++; if (completed !== 1'b1) $display("FAIL empty_completed: got %0b want 1 within 3 cycles", completed); else passed++;
    checks++; if (segs.size() != 0) $display("FAIL empty_no_req: got %0d segments want 0", segs.size()); else passed++;
  endtask

  task automatic test_timeout();
    int n;
    int t0;
    write_entry(0, 32'h300, 32'h3FF, 3'd0, 1'b1);
    reader_on = 0;
    segs.delete();
    pulse_go();
    n = 0;
    while (segs.size() == 0 && n < 50) begin @(negedge clk); n++; end
    t0 = (segs.size() > 0) ? segs[0].at : cyc;
    n = 0;
    while (error !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (error !== 1'b1 || (cyc - t0) < ACK || (cyc - t0) > ACK + 2)
      $display("FAIL timeout_error: error=%0b after %0d cycles, want 1 after %0d..%0d", error, cyc - t0, ACK, ACK + 2);
    else passed++;
    checks++; if (start_flag !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_outputs: start_flag=%0b busy=%0b want 0/0", start_flag, busy); else passed++;
    checks++; if (completed !== 1'b0) $display("FAIL timeout_completed: got %0b want 0", completed); else passed++;
    reader_on = 1;
  endtask

  task automatic test_bad_entry();
    write_entry(0, 32'h200, 32'h100, 3'd0, 1'b1);
    segs.delete();
    pulse_go();
    wait_idle(50, "bad");
    checks++; if (error !== 1'b1 || completed !== 1'b0) $display("FAIL bad_status: error=%0b completed=%0b want 1/0", error, completed); else passed++;
    checks++; if (segs.size() != 0) $display("FAIL bad_no_req: got %0d segments want 0", segs.size()); else passed++;
  endtask

  task automatic test_abort();
    int n;
    clear_table();
    write_entry(0, 32'h0, 32'hFF, 3'd1, 1'b1);
    write_entry(1, 32'h100, 32'h1FF, 3'd1, 1'b1);
    busy_len = 40;
    segs.delete();
    pulse_go();
    wait_in_read("abort");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || start_flag !== 1'b0) $display("FAIL abort_outputs: busy=%0b start_flag=%0b want 0/0", busy, start_flag); else passed++;
    checks++; if (completed !== 1'b0 || error !== 1'b0) $display("FAIL abort_flags: completed=%0b error=%0b want 0/0", completed, error); else passed++;
    go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL abort_beats_go: busy=%0b want 0", busy); else passed++;
    n = 0;
    while (phase != 0 && n < 100) begin @(negedge clk); n++; end
    busy_len = 4;
    segs.delete();
    pulse_go();
    wait_idle(500, "restart");
    checks++; if (segs.size() != 2) $display("FAIL restart_count: got %0d want 2", segs.size()); else passed++;
    if (segs.size() >= 1) begin
      checks++; if (segs[0].idx !== 2'd0 || segs[0].s !== 32'h0) $display("FAIL restart_idx0: got idx%0d %h want idx0 0", segs[0].idx, segs[0].s); else passed++;
    end
    checks++; if (completed !== 1'b1) $display("FAIL restart_completed: got %0b want 1", completed); else passed++;
  endtask

  task automatic test_cfg_busy();
    clear_table();
    write_entry(0, 32'h0, 32'hFF, 3'd1, 1'b1);
    busy_len = 20;
    pulse_go();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL cfgbusy_busy: got %0b want 1", busy); else passed++;
    write_entry(0, 32'h5000, 32'h50FF, 3'd2, 1'b1);
    write_entry(1, 32'h6000, 32'h60FF, 3'd2, 1'b1);
    wait_idle(500, "cfgbusy");
    busy_len = 4;
    segs.delete();
    pulse_go();
    wait_idle(500, "cfgbusy_rerun");
    checks++; if (segs.size() != 1) $display("FAIL cfgbusy_count: got %0d want 1", segs.size()); else passed++;
    if (segs.size() >= 1) begin
      checks++; if (segs[0].s !== 32'h0 || segs[0].e !== 32'hFF || segs[0].m !== 3'd1)
        $display("FAIL cfgbusy_entry: got %h..%h mode%0d want 0..ff mode1", segs[0].s, segs[0].e, segs[0].m); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_table();
    write_entry(0, 32'h40, 32'h4F, 3'd3, 1'b1);
    busy_len = 40;
    pulse_go();
    wait_in_read("rstmid");
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, start_flag, read_req, switch_die_need, completed, error} !== 6'b0)
      $display("FAIL rstmid_ctrl: got %b want 000000", {busy, start_flag, read_req, switch_die_need, completed, error});
    else passed++;
    checks++;
    if (start_addr !== 32'h0 || end_addr !== 32'h0 || mode !== 3'd0 || cur_idx !== 2'd0)
      $display("FAIL rstmid_data: got %h/%h/%0d/%0d want 0/0/0/0", start_addr, end_addr, mode, cur_idx);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_len = 4;
    segs.delete();
    pulse_go();
    n = 0;
    while (completed !== 1'b1 && n < 3) begin @(negedge clk); n++; end
    checks++; if (completed !== 1'b1 || segs.size() != 0) $display("FAIL rstmid_table_cleared: completed=%0b segments=%0d want 1/0", completed, segs.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_die_split();
    test_multi_die();
    test_skip();
    test_timeout();
    test_bad_entry();
    test_abort();
    test_cfg_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded 500us, passed %0d of %0d", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
